// File: rtl/alu_server_if.sv
// alu_server_if: per-client request lanes and broadcast result bus of the shared ALU server.
`ifndef PID_RES
`define PID_RES 32
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 8
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 2
`endif
`ifndef ADD
`define ADD 2'd0
`endif
`ifndef SUB
`define SUB 2'd1
`endif
`ifndef MUL
`define MUL 2'd2
`endif

interface alu_server_if #(
    parameter int nbits    = `PID_RES,
    parameter int nclients = 2
);
    logic [nclients*`KEY_SIZE-1:0]    req_key_i;
    logic [nclients*`OPCODE_SIZE-1:0] req_op_i;
    logic [nclients*nbits-1:0]        req_A_i;
    logic [nclients*nbits-1:0]        req_B_i;
    logic [`KEY_SIZE-1:0]             res_key_o;
    logic [nbits-1:0]                 res_O_o;
    logic                             busy_o;

    modport master (
        output req_key_i, req_op_i, req_A_i, req_B_i,
        input  res_key_o, res_O_o, busy_o
    );

    modport slave (
        input  req_key_i, req_op_i, req_A_i, req_B_i,
        output res_key_o, res_O_o, busy_o
    );
endinterface

// File: rtl/alu_server.sv
// alu_server: round-robin shared ALU serving ADD/SUB in one cycle and fixed-point MUL by iterative shift-add.
`ifndef PID_RES
`define PID_RES 32
`endif
`ifndef KEY_SIZE
`define KEY_SIZE 8
`endif
`ifndef OPCODE_SIZE
`define OPCODE_SIZE 2
`endif
`ifndef ADD
`define ADD 2'd0
`endif
`ifndef SUB
`define SUB 2'd1
`endif
`ifndef MUL
`define MUL 2'd2
`endif

module alu_server #(
    parameter int nbits    = `PID_RES,
    parameter int nclients = 2,
    parameter int frac     = 16
) (
    input logic        clk,
    input logic        rst,
    alu_server_if.slave bus
);
    localparam int kw = `KEY_SIZE;
    localparam int ow = `OPCODE_SIZE;
    localparam int iw = nclients > 1 ? $clog2(nclients) : 1;
    localparam int cw = $clog2(nbits + 1);

    typedef enum logic {IDLE, EXEC} state_t;
    state_t state, state_nx;

    logic [kw-1:0]      last_key [nclients];
    logic [nclients-1:0] pending;
    logic [iw-1:0]      ptr, sel, idx, gnt;
    logic               found, done;
    logic [kw-1:0]      key_q, sel_key;
    logic [ow-1:0]      op_q, sel_op;
    logic [nbits-1:0]   a_q, b_q, sel_a, sel_b, mplier, result;
    logic [2*nbits-1:0] acc, acc_nx, mcand;
    logic [cw-1:0]      cnt;

    assign sel_key = bus.req_key_i[int'(sel)*kw +: kw];
    assign sel_op  = bus.req_op_i[int'(sel)*ow +: ow];
    assign sel_a   = bus.req_A_i[int'(sel)*nbits +: nbits];
    assign sel_b   = bus.req_B_i[int'(sel)*nbits +: nbits];
    assign bus.busy_o = state == EXEC;

    always_comb begin
        pending = '0;
        for (int k = 0; k < nclients; k++)
            pending[k] = bus.req_key_i[k*kw +: kw] != '0 && bus.req_key_i[k*kw +: kw] != last_key[k];
    end

    // Scan from highest offset down so the client closest after ptr wins.
    always_comb begin
        found = 1'b0;
        sel = ptr;
        idx = '0;
        for (int i = nclients - 1; i >= 0; i--) begin
            idx = iw'((int'(ptr) + i) % nclients);
            if (pending[idx]) begin
                found = 1'b1;
                sel = idx;
            end
        end
    end

    // The MSB of the multiplier carries negative weight in two's complement, so the last step subtracts.
    always_comb begin
        acc_nx = acc + (mplier[0] ? (cnt == cw'(nbits - 1) ? -mcand : mcand) : '0);
        result = op_q == `ADD ? a_q + b_q : op_q == `SUB ? a_q - b_q : op_q == `MUL ? acc_nx[frac +: nbits] : '0;
        done = state == EXEC && (op_q != `MUL || cnt == cw'(nbits - 1));
        state_nx = state == IDLE ? (found ? EXEC : IDLE) : (done ? IDLE : EXEC);
    end

    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            gnt <= '0;
            key_q <= '0;
            op_q <= '0;
            a_q <= '0;
            b_q <= '0;
            acc <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
            bus.res_key_o <= '0;
            bus.res_O_o <= '0;
            for (int k = 0; k < nclients; k++) last_key[k] <= '0;
        end else begin
            state <= state_nx;
            for (int k = 0; k < nclients; k++)
                if (bus.req_key_i[k*kw +: kw] == '0) last_key[k] <= '0;
            if (state == IDLE && found) begin
                gnt <= sel;
                ptr <= iw'((int'(sel) + 1) % nclients);
                key_q <= sel_key;
                op_q <= sel_op;
                a_q <= sel_a;
                b_q <= sel_b;
                acc <= '0;
                mcand <= {{nbits{sel_a[nbits-1]}}, sel_a};
                mplier <= sel_b;
                cnt <= '0;
            end
            if (state == EXEC && op_q == `MUL) begin
                acc <= acc_nx;
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                cnt <= cnt + 1'b1;
            end
            if (done) begin
                bus.res_key_o <= key_q;
                bus.res_O_o <= result;
                last_key[gnt] <= key_q;
            end
        end
endmodule
